// File: rtl/weight_lut_pkg.sv
// Shared constants and FSM state encoding for the weight LUT loader.
package weight_lut_pkg;
  localparam int NUM_BANKS  = 4;
  localparam int BANK_W     = 2;
  localparam int DEPTH      = 512;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 8;
  localparam int CHECKSUM_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/weight_lut_addr_gen.sv
// Bank/address counter pair for the loader; bank is the fast-moving digit.
module weight_lut_addr_gen
  import weight_lut_pkg::*;
#(
  parameter int DEPTH  = weight_lut_pkg::DEPTH,
  parameter int ADDR_W = weight_lut_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [BANK_W-1:0] bank,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic bank_wrap;
  assign bank_wrap = (bank == BANK_W'(NUM_BANKS - 1));
  assign last      = bank_wrap && (addr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bank <= '0;
      addr <= '0;
    end else if (inc) begin
      bank <= bank + 1'b1;
      if (bank_wrap) addr <= addr + 1'b1;
    end
  end
endmodule

// File: rtl/weight_lut_loader.sv
// De-interleaves a byte stream into four weight banks with a 1-cycle write stage.
// Optional trailer checksum verification: define WEIGHT_LUT_LOADER_CHECKSUM_EN.
module weight_lut_loader
  import weight_lut_pkg::*;
#(
  parameter int DEPTH  = weight_lut_pkg::DEPTH,
  parameter int ADDR_W = weight_lut_pkg::ADDR_W,
  parameter int DATA_W = weight_lut_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic [NUM_BANKS-1:0] wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 rd_inhibit,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  state_e            state;
  logic              acc, data_acc, go, last;
  logic [BANK_W-1:0] bank;
  logic [ADDR_W-1:0] addr;

  assign busy     = (state == ST_LOAD) || (state == ST_CHECK);
  assign in_ready = busy;
  assign done     = (state == ST_DONE);
  assign acc      = in_valid && in_ready;
  assign data_acc = acc && (state == ST_LOAD);
  // abort beats start when both arrive in IDLE
  assign go       = (state == ST_IDLE) && start && !abort;

  weight_lut_addr_gen #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (go),
    .inc  (data_acc),
    .bank (bank),
    .addr (addr),
    .last (last)
  );

`ifdef WEIGHT_LUT_LOADER_CHECKSUM_EN
  logic [CHECKSUM_W-1:0] sum;
  logic [DATA_W-1:0]     chk_lo;
  logic                  chk_hi;
  logic                  match;

  assign match = ({in_data, chk_lo} == sum);

  always_ff @(posedge clk) begin
    if (rst || go) begin
      sum    <= '0;
      chk_lo <= '0;
      chk_hi <= 1'b0;
    end else begin
      if (data_acc) sum <= sum + CHECKSUM_W'(in_data);
      if (acc && (state == ST_CHECK) && !chk_hi) begin
        chk_lo <= in_data;
        chk_hi <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rd_inhibit <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (go) begin
          state      <= ST_LOAD;
          rd_inhibit <= 1'b1;
          err        <= 1'b0;
        end
        ST_LOAD: begin
          // rd_inhibit is left high on abort: the banks hold a partial table
          if (abort) begin
            state <= ST_IDLE;
            err   <= 1'b1;
          end else if (data_acc && last) begin
`ifdef WEIGHT_LUT_LOADER_CHECKSUM_EN
            state <= ST_CHECK;
`else
            state      <= ST_DONE;
            rd_inhibit <= 1'b0;
`endif
          end
        end
`ifdef WEIGHT_LUT_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (abort) begin
            state <= ST_IDLE;
            err   <= 1'b1;
          end else if (acc && chk_hi) begin
            state <= ST_DONE;
            if (match) rd_inhibit <= 1'b0;
            err <= !match;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write stage: a beat accepted in the abort cycle still lands next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= data_acc ? (NUM_BANKS'(1) << bank) : '0;
      if (data_acc) begin
        wr_addr <= addr;
        wr_data <= in_data;
      end
    end
  end
endmodule
